// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// default reset vector, NOP encoding and address alignment helper.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc4_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc4_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0;
      pc4_q   <= 32'h0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + 32'd4;
    end else if (bubble_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem requests,
// branch redirect (delay slot or squash) and a one-entry hold buffer.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic        DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  tgt_q;
  logic [31:0]  hold_instr_q;
  logic [31:0]  hold_pc_q;
  logic         redir_pend_q;
  logic         kill_pend_q;

  logic         redir;
  logic         kill_now;
  logic [31:0]  br_tgt;
  logic [31:0]  pc_next_seq;

  logic         ifid_load;
  logic         ifid_bubble;
  logic [31:0]  ifid_instr;
  logic [31:0]  ifid_pc;

  assign redir       = br_valid & br_taken & ~stall;
  assign br_tgt      = word_align(br_target);
  assign pc_next_seq = redir_pend_q ? tgt_q : (pc_q + 32'd4);
  // In squash mode the word returning alongside a taken branch is the one to drop.
  assign kill_now    = kill_pend_q | (~DELAY_SLOT & redir);

  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;

  always_comb begin
    ifid_load  = 1'b0;
    ifid_instr = imem_rdata;
    ifid_pc    = pc_q;
    case (state_q)
      ST_REQ: begin
        ifid_load = imem_ready & ~kill_now & ~stall;
      end
      ST_HOLD: begin
        ifid_load  = ~stall & ~(~DELAY_SLOT & redir);
        ifid_instr = hold_instr_q;
        ifid_pc    = hold_pc_q;
      end
      default: ifid_load = 1'b0;
    endcase
    ifid_bubble = ~stall & ~ifid_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RST;
      pc_q         <= RESET_PC;
      tgt_q        <= 32'h0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= 32'h0;
      redir_pend_q <= 1'b0;
      kill_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_ready) begin
            if (kill_now) begin
              pc_q         <= redir ? br_tgt : tgt_q;
              redir_pend_q <= 1'b0;
              kill_pend_q  <= 1'b0;
            end else if (!stall) begin
              pc_q         <= redir ? br_tgt : pc_next_seq;
              redir_pend_q <= 1'b0;
            end else begin
              hold_instr_q <= imem_rdata;
              hold_pc_q    <= pc_q;
              pc_q         <= pc_next_seq;
              redir_pend_q <= 1'b0;
              state_q      <= ST_HOLD;
            end
          end else if (redir) begin
            // Address must stay stable while waiting; remember the target instead.
            tgt_q        <= br_tgt;
            redir_pend_q <= 1'b1;
            if (!DELAY_SLOT) kill_pend_q <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (redir) begin
            pc_q    <= br_tgt;
            state_q <= ST_REQ;
          end else if (!stall) begin
            state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase
    end
  end

  // A second redirect before the first is taken would silently lose a target.
  a_no_double_redir: assert property (@(posedge clk) disable iff (!rst_n)
    !(redir && redir_pend_q));

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .instr_i  (ifid_instr),
    .pc_i     (ifid_pc),
    .valid_o  (id_valid),
    .instr_o  (id_instr),
    .pc_o     (id_pc),
    .pc4_o    (id_pc4)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: one delay-slot and one squash instance, run in turn,
// with a queue scoreboard checking every word delivered into IF/ID.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  logic [1:0]  stall;
  logic [1:0]  br_valid;
  logic [1:0]  br_taken;
  logic [31:0] br_target  [2];
  logic [1:0]  imem_req;
  logic [31:0] imem_addr  [2];
  logic [1:0]  imem_ready;
  logic [31:0] imem_rdata [2];
  logic [1:0]  id_valid;
  logic [31:0] id_instr   [2];
  logic [31:0] id_pc      [2];
  logic [31:0] id_pc4     [2];

  int          n_chk   = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;
  int          d       = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Instance 0 runs with a delay slot, instance 1 squashes the post-branch word.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign imem_rdata[gi] = imem_addr[gi];
    if_fetch_stage #(
      .RESET_PC   (32'h0000_3000),
      .DELAY_SLOT ((gi == 0) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[gi]),
      .stall      (stall[gi]),
      .br_valid   (br_valid[gi]),
      .br_taken   (br_taken[gi]),
      .br_target  (br_target[gi]),
      .imem_req   (imem_req[gi]),
      .imem_addr  (imem_addr[gi]),
      .imem_ready (imem_ready[gi]),
      .imem_rdata (imem_rdata[gi]),
      .id_valid   (id_valid[gi]),
      .id_instr   (id_instr[gi]),
      .id_pc      (id_pc[gi]),
      .id_pc4     (id_pc4[gi])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got %h expected %h", name, d, act, exp);
    end else begin
      $display("ok   %s (dut%0d): %h", name, d, act);
    end
  endtask

  // Monitor: a word was loaded into IF/ID whenever the edge saw no stall/reset and valid is up.
  initial begin
    logic        st;
    logic        rs;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      st = stall[d];
      rs = rst_n[d];
      #1;
      if (rs && !st && id_valid[d]) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_delivery (dut%0d): got pc %h expected none", d, id_pc[d]);
        end else begin
          e = exp_q.pop_front();
          check("deliv_instr", id_instr[d], e);
          check("deliv_pc", id_pc[d], e);
          check("deliv_pc4", id_pc4[d], e + 32'd4);
        end
      end
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic set_br(input logic v, input logic [31:0] tgt);
    br_valid[d]  = v;
    br_taken[d]  = v;
    br_target[d] = tgt;
  endtask

  initial begin
    logic ds;
    rst_n      = 2'b00;
    stall      = 2'b00;
    br_valid   = 2'b00;
    br_taken   = 2'b00;
    imem_ready = 2'b11;
    br_target[0] = 32'h0;
    br_target[1] = 32'h0;

    for (int k = 0; k < 2; k++) begin
      d  = k;
      ds = (k == 0);

      // Reset, sequential fetch, taken branch, stall with ignored branch
      rst_n[d] = 1'b0;
      repeat (2) nxt();
      check("rst_id_valid", {31'b0, id_valid[d]}, 32'd0);
      check("rst_id_instr", id_instr[d], 32'h0);
      check("rst_id_pc", id_pc[d], 32'h0);
      check("rst_id_pc4", id_pc4[d], 32'h0);
      check("rst_imem_req", {31'b0, imem_req[d]}, 32'd0);
      check("rst_imem_addr", imem_addr[d], 32'h3000);
      exp_q.delete();
      n_deliv = 0;
      exp_q.push_back(32'h3000);
      exp_q.push_back(32'h3004);
      if (ds) exp_q.push_back(32'h3008);
      for (int i = 0; i < 8; i++) exp_q.push_back(32'h3100 + 32'(4 * i));
      rst_n[d] = 1'b1;
      nxt();
      check("first_req", {31'b0, imem_req[d]}, 32'd1);
      check("first_addr", imem_addr[d], 32'h3000);
      check("first_valid_low", {31'b0, id_valid[d]}, 32'd0);
      nxt();
      check("valid_two_cycles", {31'b0, id_valid[d]}, 32'd1);
      check("addr_3004", imem_addr[d], 32'h3004);
      nxt();
      check("id_pc_3004", id_pc[d], 32'h3004);
      check("addr_3008", imem_addr[d], 32'h3008);
      set_br(1'b1, 32'h0000_3103);
      nxt();
      set_br(1'b0, 32'h0);
      check("branch_slot_valid", {31'b0, id_valid[d]}, {31'b0, ds});
      check("branch_addr", imem_addr[d], 32'h3100);
      nxt();
      nxt();
      stall[d] = 1'b1;
      nxt();
      check("stall_req_low", {31'b0, imem_req[d]}, 32'd0);
      check("stall_hold_pc", id_pc[d], 32'h3104);
      check("stall_hold_valid", {31'b0, id_valid[d]}, 32'd1);
      set_br(1'b1, 32'h0000_3F00);
      nxt();
      set_br(1'b0, 32'h0);
      check("stall_hold_pc2", id_pc[d], 32'h3104);
      nxt();
      check("stall_req_low2", {31'b0, imem_req[d]}, 32'd0);
      stall[d] = 1'b0;
      repeat (4) nxt();
      check("phaseA_deliveries", 32'(n_deliv), ds ? 32'd9 : 32'd8);

      // Wait states with redirect during the wait, then reset mid-wait
      rst_n[d] = 1'b0;
      exp_q.delete();
      n_deliv = 0;
      exp_q.push_back(32'h3000);
      exp_q.push_back(32'h3004);
      if (ds) exp_q.push_back(32'h3008);
      exp_q.push_back(32'h3200);
      exp_q.push_back(32'h3204);
      nxt();
      rst_n[d] = 1'b1;
      repeat (3) nxt();
      imem_ready[d] = 1'b0;
      nxt();
      check("wait_req", {31'b0, imem_req[d]}, 32'd1);
      check("wait_addr0", imem_addr[d], 32'h3008);
      set_br(1'b1, 32'h0000_3200);
      nxt();
      set_br(1'b0, 32'h0);
      check("wait_addr1", imem_addr[d], 32'h3008);
      check("wait_bubble", {31'b0, id_valid[d]}, 32'd0);
      nxt();
      check("wait_addr2", imem_addr[d], 32'h3008);
      nxt();
      check("wait_addr3", imem_addr[d], 32'h3008);
      imem_ready[d] = 1'b1;
      nxt();
      check("pend_redir_addr", imem_addr[d], 32'h3200);
      check("pend_slot_valid", {31'b0, id_valid[d]}, {31'b0, ds});
      nxt();
      nxt();
      imem_ready[d] = 1'b0;
      nxt();
      rst_n[d] = 1'b0;
      #1;
      check("midrst_req", {31'b0, imem_req[d]}, 32'd0);
      check("midrst_valid", {31'b0, id_valid[d]}, 32'd0);
      check("midrst_instr", id_instr[d], 32'h0);
      check("midrst_pc", id_pc[d], 32'h0);
      check("midrst_pc4", id_pc4[d], 32'h0);
      check("midrst_addr", imem_addr[d], 32'h3000);
      check("phaseB_deliveries", 32'(n_deliv), ds ? 32'd5 : 32'd4);

      // Restart with a late ready held high, then branch to the top of memory
      exp_q.delete();
      n_deliv = 0;
      exp_q.push_back(32'h3000);
      exp_q.push_back(32'h3004);
      if (ds) exp_q.push_back(32'h3008);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h0000_0004);
      imem_ready[d] = 1'b1;
      nxt();
      rst_n[d] = 1'b1;
      nxt();
      check("late_ready_ignored", {31'b0, id_valid[d]}, 32'd0);
      check("restart_addr", imem_addr[d], 32'h3000);
      nxt();
      nxt();
      set_br(1'b1, 32'hFFFF_FFFF);
      nxt();
      set_br(1'b0, 32'h0);
      check("wrap_target_addr", imem_addr[d], 32'hFFFF_FFFC);
      nxt();
      check("wrap_addr_zero", imem_addr[d], 32'h0);
      nxt();
      nxt();
      check("phaseC_deliveries", 32'(n_deliv), ds ? 32'd6 : 32'd5);
      rst_n[d] = 1'b0;
      nxt();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
